// File: rtl/sgpr_wr_port_arbiter_if.sv
// Bundles the SGPR write-port arbiter signals.
// Sources drive req/lock through the master modport, and the arbiter answers through the slave modport.
interface sgpr_wr_port_arbiter_if #(
  parameter int NUM_PORTS = 10,
  parameter int SEL_WIDTH = 16
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] lock;
  logic [NUM_PORTS-1:0] gnt;
  logic [SEL_WIDTH-1:0] wr_port_select;
  logic                 busy;
  logic [3:0]           hold_cnt;

  modport master (
    output req,
    output lock,
    input  gnt,
    input  wr_port_select,
    input  busy,
    input  hold_cnt
  );

  modport slave (
    input  req,
    input  lock,
    output gnt,
    output wr_port_select,
    output busy,
    output hold_cnt
  );
endinterface

// File: rtl/sgpr_wr_port_arbiter.sv
// Round-robin arbiter for the SGPR write port, with a registered one-hot grant.
// A source that asserts lock can hold the port for several beats, but only up to MAX_LOCK cycles in a row.
module sgpr_wr_port_arbiter #(
  parameter int NUM_PORTS = 10,
  parameter int SEL_WIDTH = 16,
  parameter int MAX_LOCK  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sgpr_wr_port_arbiter_if.slave wr_bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] gnt_q;
  logic [NUM_PORTS-1:0] gnt_d;
  logic [NUM_PORTS-1:0] cand;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_d;
  logic [PTR_W-1:0]     scan_idx;
  logic [3:0]           hold_q;
  logic [3:0]           hold_d;
  logic                 keep;
  logic                 found;

  // The current grantee is removed from the candidate set, so a non-locked or
  // limit-cut source always yields for at least one arbitration.
  always_comb begin
    keep     = (|(gnt_q & wr_bus.req & wr_bus.lock)) && (hold_q < 4'(MAX_LOCK - 1));
    cand     = wr_bus.req & ~gnt_q;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    hold_d   = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (keep) begin
      gnt_d  = gnt_q;
      hold_d = hold_q + 4'd1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
        if (!found && cand[scan_idx]) begin
          found           = 1'b1;
          gnt_d[scan_idx] = 1'b1;
          ptr_d           = PTR_W'((int'(scan_idx) + 1) % NUM_PORTS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= '0;
      ptr_q  <= '0;
      hold_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end

  assign wr_bus.gnt            = gnt_q;
  assign wr_bus.wr_port_select = SEL_WIDTH'(gnt_q);
  assign wr_bus.busy           = |gnt_q;
  assign wr_bus.hold_cnt       = hold_q;

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
// Scoreboard bench for sgpr_wr_port_arbiter.
// Each stimulus cycle queues the grant expected after the next edge, and a monitor checks the result 1ns after that edge.
module tb_sgpr_wr_port_arbiter;

  localparam int NUM_PORTS = 10;
  localparam int SEL_WIDTH = 16;
  localparam int MAX_LOCK  = 4;

  typedef struct {
    logic [NUM_PORTS-1:0] gnt;
    logic [3:0]           hold;
    string                tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sgpr_wr_port_arbiter_if #(.NUM_PORTS(NUM_PORTS), .SEL_WIDTH(SEL_WIDTH)) wr_bus();

  sgpr_wr_port_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .SEL_WIDTH(SEL_WIDTH),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_bus(wr_bus)
  );

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", what, act, want);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, and record what must appear after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [NUM_PORTS-1:0] rq,
                               input logic [NUM_PORTS-1:0] lk, input logic [NUM_PORTS-1:0] eg,
                               input logic [3:0] eh, input string tag);
    exp_t e;
    @(negedge clk);
    rst         = r;
    wr_bus.req  = rq;
    wr_bus.lock = lk;
    e.gnt  = eg;
    e.hold = eh;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.tag, " gnt"},      32'(wr_bus.gnt),            32'(e.gnt));
        checkOutput({e.tag, " select"},   32'(wr_bus.wr_port_select), 32'(SEL_WIDTH'(e.gnt)));
        checkOutput({e.tag, " busy"},     32'(wr_bus.busy),           32'(|e.gnt));
        checkOutput({e.tag, " hold_cnt"}, 32'(wr_bus.hold_cnt),       32'(e.hold));
      end
    end
  end

  initial begin : stimulus
    int waited;
    wr_bus.req  = '0;
    wr_bus.lock = '0;

    // Reset dominates requests and locks.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10'h3FF, 10'h3FF, 10'h000, 4'd0, "reset");

    // Round-robin walk from ptr=0, then wrap back to port 0.
    for (int i = 0; i < 11; i++)
      applyStimulus(1'b0, 10'h3FF, 10'h000, 10'(1 << (i % NUM_PORTS)), 4'd0, $sformatf("rr%0d", i));

    // A lone requester is granted only every other cycle.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 10'h004, 10'h000, (i % 2 == 0) ? 10'h004 : 10'h000, 4'd0, $sformatf("single%0d", i));

    // Grant port 8 to move ptr to 9, then lock port 9 up to the limit.
    applyStimulus(1'b0, 10'h100, 10'h000, 10'h100, 4'd0, "ptr_to_9");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h200, 4'd0, "lock_h0");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h200, 4'd1, "lock_h1");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h200, 4'd2, "lock_h2");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h200, 4'd3, "lock_h3");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h001, 4'd0, "limit_yield");
    applyStimulus(1'b0, 10'h201, 10'h200, 10'h200, 4'd0, "regain9");
    applyStimulus(1'b0, 10'h000, 10'h000, 10'h000, 4'd0, "idle");

    // Port 3 locks for two beats, then drops lock while port 6 is waiting.
    applyStimulus(1'b0, 10'h008, 10'h008, 10'h008, 4'd0, "rel_h0");
    applyStimulus(1'b0, 10'h008, 10'h008, 10'h008, 4'd1, "rel_h1");
    applyStimulus(1'b0, 10'h048, 10'h000, 10'h040, 4'd0, "rel_to6");
    applyStimulus(1'b0, 10'h048, 10'h000, 10'h008, 4'd0, "rel_back3");
    applyStimulus(1'b0, 10'h000, 10'h008, 10'h000, 4'd0, "lock_no_req");

    // Reset in the middle of a lock on port 7.
    applyStimulus(1'b0, 10'h080, 10'h080, 10'h080, 4'd0, "mid_h0");
    applyStimulus(1'b0, 10'h080, 10'h080, 10'h080, 4'd1, "mid_h1");
    applyStimulus(1'b1, 10'h080, 10'h080, 10'h000, 4'd0, "mid_rst");
    applyStimulus(1'b0, 10'h0A0, 10'h000, 10'h020, 4'd0, "post_rst_low");
    applyStimulus(1'b0, 10'h0A0, 10'h000, 10'h080, 4'd0, "post_rst_next");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
